sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param_if.sv | 47 ++++
 rtl/sync_fifo_param.sv | 130 +++++++++++++
 tb/tb_sync_fifo_param.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
// Bundles the write/read request side and the status/data side of the
// synchronous FIFO.
//
// Handshake semantics:
//   A write request (wr_en) is taken at a rising edge when the FIFO is not full,
//   or when it is full and a read is taken at the same edge. A read request
//   (rd_en) is taken at a rising edge when the FIFO is not empty. A taken read
//   presents its word on output_data with rd_valid high in the next cycle only.
//   A request that is not taken produces a one-cycle overflow or underflow pulse
//   in the next cycle. Requests need not be held. A rejected request is simply
//   dropped.
//
// Modports:
//   master : drives wr_en, rd_en, input_data; observes data and status
//   slave  : the FIFO side
// -----------------------------------------------------------------------------
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int PTR_W = 4
);
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] input_data;
  logic [WIDTH-1:0] output_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, rd_en, input_data,
    input  output_data, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, input_data,
    output output_data, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with registered read data, registered status flags,
// programmable almost-full/almost-empty thresholds and one-cycle
// overflow/underflow pulses.
//
// Ports:
//   clk   : single clock, all state on the rising edge
//   reset : synchronous, active-high; clears pointers, count, flags, output data
//   bus   : sync_fifo_param_if.slave
//             wr_en, rd_en, input_data      (in)
//             output_data, rd_valid         (out, registered read data)
//             empty, full, almost_empty,
//             almost_full, count            (out, registered status)
//             overflow, underflow           (out, one-cycle pulses)
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int PTR_W    = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sync_fifo_param_if.slave     bus
);

  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra bit so they wrap modulo 2*DEPTH.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             almost_full_q, almost_full_d;

  logic [WIDTH-1:0] output_data_q, output_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             get;
  logic             put;

  // A write into a full FIFO is taken when a read frees a slot at the same edge.
  assign get = bus.rd_en && !empty_q;
  assign put = bus.wr_en && (!full_q || get);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    output_data_d = output_data_q;

    if (put) wr_ptr_d = wr_ptr_q + 1'b1;
    if (get) begin
      rd_ptr_d      = rd_ptr_q + 1'b1;
      output_data_d = mem[rd_ptr_q[PTR_W-1:0]];
    end

    if (put && !get)      count_d = count_q + 1'b1;
    else if (get && !put) count_d = count_q - 1'b1;

    // Flags follow the next count so they agree with count in the same cycle.
    empty_d        = (count_d == '0);
    full_d         = (count_d == DEPTH_C);
    almost_empty_d = (count_d <= AE_C);
    almost_full_d  = (count_d >= AF_C);

    rd_valid_d     = get;
    overflow_d     = bus.wr_en && !put;
    underflow_d    = bus.rd_en && !get;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      output_data_q  <= '0;
      rd_valid_q     <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      output_data_q  <= output_data_d;
      rd_valid_q     <= rd_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage has no reset; writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (put && !reset) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= bus.input_data;
    end
  end

  assign bus.output_data  = output_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int PTR_W = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;

  int checks;
  int errors;

  logic [WIDTH-1:0] exp_q[$];
  int               model_cnt;

  sync_fifo_param_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) bus_if ();

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W), .AF_LEVEL(12), .AE_LEVEL(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Advance past one rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    bus_if.wr_en      = wr;
    bus_if.rd_en      = rd;
    bus_if.input_data = d;
  endtask

  task automatic check_status(input string tag, input int cnt);
    check({tag, "_count"}, 32'(bus_if.count), 32'(cnt));
    check({tag, "_empty"}, 32'(bus_if.empty), 32'(cnt == 0));
    check({tag, "_full"},  32'(bus_if.full),  32'(cnt == DEPTH));
    check({tag, "_ae"},    32'(bus_if.almost_empty), 32'(cnt <= 4));
    check({tag, "_af"},    32'(bus_if.almost_full),  32'(cnt >= 12));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [WIDTH-1:0] exp_word;
    logic             g, p;
    logic             wr, rd;
    logic [WIDTH-1:0] d;

    checks = 0;
    errors = 0;
    model_cnt = 0;

    // Reset with requests active: they must be ignored.
    reset = 1'b1;
    drive(1'b1, 1'b1, 8'h77);
    tick();
    tick();
    check_status("rst", 0);
    check("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    check("rst_ovf",      32'(bus_if.overflow), 32'd0);
    check("rst_unf",      32'(bus_if.underflow), 32'd0);
    check("rst_out",      32'(bus_if.output_data), 32'h0);

    reset = 1'b0;
    drive(1'b0, 1'b0, '0);
    tick();
    check_status("idle", 0);

    // Fill with 0x00..0x0F; flags tracked at every step.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      exp_q.push_back(8'(i));
      tick();
      check_status($sformatf("fill%0d", i), i + 1);
    end

    // 17th write alone is dropped.
    drive(1'b1, 1'b0, 8'h55);
    tick();
    check("ovf_pulse", 32'(bus_if.overflow), 32'd1);
    check_status("ovf", 16);
    drive(1'b0, 1'b0, '0);
    tick();
    check("ovf_clear", 32'(bus_if.overflow), 32'd0);

    // Full with simultaneous read and write.
    drive(1'b1, 1'b1, 8'hAA);
    void'(exp_q.pop_front());
    exp_q.push_back(8'hAA);
    tick();
    check("rw_full_out",   32'(bus_if.output_data), 32'h00);
    check("rw_full_valid", 32'(bus_if.rd_valid), 32'd1);
    check("rw_full_ovf",   32'(bus_if.overflow), 32'd0);
    check_status("rw_full", 16);

    // Drain all 16 words in order; last one is 0xAA.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, '0);
      exp_word = exp_q.pop_front();
      tick();
      check($sformatf("drain%0d_out", i), 32'(bus_if.output_data), 32'(exp_word));
      check($sformatf("drain%0d_vld", i), 32'(bus_if.rd_valid), 32'd1);
      check_status($sformatf("drain%0d", i), DEPTH - 1 - i);
    end
    check("last_is_aa", 32'(bus_if.output_data), 32'hAA);

    // Read on empty.
    drive(1'b0, 1'b1, '0);
    tick();
    check("unf_pulse", 32'(bus_if.underflow), 32'd1);
    check("unf_valid", 32'(bus_if.rd_valid), 32'd0);
    check("unf_out",   32'(bus_if.output_data), 32'hAA);
    check_status("unf", 0);
    drive(1'b0, 1'b0, '0);
    tick();
    check("unf_clear", 32'(bus_if.underflow), 32'd0);
    check("hold_out",  32'(bus_if.output_data), 32'hAA);

    // Write on empty with rd_en: write taken, read rejected.
    drive(1'b1, 1'b1, 8'h33);
    tick();
    check("wre_unf",   32'(bus_if.underflow), 32'd1);
    check("wre_valid", 32'(bus_if.rd_valid), 32'd0);
    check_status("wre", 1);
    // Read in the following cycle: word appears after that edge.
    drive(1'b0, 1'b1, '0);
    tick();
    check("wre_rd_out",   32'(bus_if.output_data), 32'h33);
    check("wre_rd_valid", 32'(bus_if.rd_valid), 32'd1);
    check("wre_rd_unf",   32'(bus_if.underflow), 32'd0);
    check_status("wre_rd", 0);
    drive(1'b0, 1'b0, '0);
    tick();
    check("vld_one_cycle", 32'(bus_if.rd_valid), 32'd0);

    // Random interleaving; pointers already sit off zero so this crosses wrap.
    model_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      wr = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 1) != 0);
      d  = 8'($urandom_range(0, 255));
      g  = rd && (model_cnt > 0);
      p  = wr && ((model_cnt < DEPTH) || g);
      exp_word = '0;
      if (g) exp_word = exp_q.pop_front();
      if (p) exp_q.push_back(d);
      model_cnt = model_cnt + (p ? 1 : 0) - (g ? 1 : 0);
      drive(wr, rd, d);
      tick();
      check($sformatf("rnd%0d_count", i), 32'(bus_if.count), 32'(model_cnt));
      check($sformatf("rnd%0d_vld", i), 32'(bus_if.rd_valid), 32'(g));
      if (g) check($sformatf("rnd%0d_out", i), 32'(bus_if.output_data), 32'(exp_word));
    end
    // Drain the remainder and confirm order.
    while (exp_q.size() > 0) begin
      exp_word = exp_q.pop_front();
      drive(1'b0, 1'b1, '0);
      tick();
      check("rnd_drain_out", 32'(bus_if.output_data), 32'(exp_word));
    end
    drive(1'b0, 1'b0, '0);
    tick();
    check_status("rnd_end", 0);

    // Reset mid-operation with count 7 and wr_en high.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 8'(8'h40 + i));
      tick();
    end
    check_status("pre_rst", 7);
    drive(1'b0, 1'b1, '0);
    tick();
    check("pre_rst_out", 32'(bus_if.output_data), 32'h40);
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'hEE);
    tick();
    check_status("mid_rst", 0);
    check("mid_rst_ovf", 32'(bus_if.overflow), 32'd0);
    check("mid_rst_out", 32'(bus_if.output_data), 32'h0);
    check("mid_rst_vld", 32'(bus_if.rd_valid), 32'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0);
    tick();
    check_status("post_rst", 0);
    check("post_rst_ovf", 32'(bus_if.overflow), 32'd0);

    // Stored words were discarded: a read now underflows.
    drive(1'b0, 1'b1, '0);
    tick();
    check("post_rst_unf", 32'(bus_if.underflow), 32'd1);
    check("post_rst_vld", 32'(bus_if.rd_valid), 32'd0);
    drive(1'b0, 1'b0, '0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
